// File: rtl/bdd_sbox_sequencer.sv
// rtl/bdd_sbox_sequencer.sv - precharge/evaluate sequencer for the dual-rail BDD S-box array
module bdd_sbox_sequencer #(
    parameter int NIBBLES     = 16,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   din,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   dout,
    output logic                   fault,
    output logic                   pre,
    output logic [3:0]             select,
    output logic [3:0]             select_bar,
    input  logic [3:0]             u_out,
    input  logic [3:0]             c_out
);

    localparam int IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int MAXC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [IW-1:0] LAST_NIB  = IW'(NIBBLES - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] EVAL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        index;
    logic [IW-1:0]        next_index;
    logic [4*NIBBLES-1:0] data;
    logic [3:0]           next_nibble;

    assign next_index  = index + 1'b1;
    assign next_nibble = data[{next_index, 2'b00} +: 4];
    // The complement rail is derived from the single select register so the
    // two can never disagree, even transiently.
    assign select_bar  = ~select;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            index  <= '0;
            data   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
            fault  <= 1'b0;
            pre    <= 1'b0;
            select <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data   <= din;
                        fault  <= 1'b0;
                        index  <= '0;
                        cnt    <= '0;
                        select <= din[3:0];
                        busy   <= 1'b1;
                        state  <= PRE;
                    end
                end
                PRE: begin
                    if (cnt == PRE_LAST) begin
                        // Both precharged rails must have discharged to 0.
                        if ((u_out | c_out) != 4'h0) begin
                            fault <= 1'b1;
                        end
                        cnt   <= '0;
                        pre   <= 1'b1;
                        state <= EVAL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (cnt == EVAL_LAST) begin
                        dout[{index, 2'b00} +: 4] <= u_out;
                        if (u_out != ~c_out) begin
                            fault <= 1'b1;
                        end
                        cnt <= '0;
                        pre <= 1'b0;
                        if (index == LAST_NIB) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            index  <= next_index;
                            select <= next_nibble;
                            state  <= PRE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    select <= 4'h0;
                    index  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdd_sbox_sequencer.sv
// tb/tb_bdd_sbox_sequencer.sv - self-checking bench for bdd_sbox_sequencer
module tb_bdd_sbox_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [63:0] din, din2;
    logic        busy, done, fault, pre;
    logic        busy2, done2, fault2, pre2;
    logic [63:0] dout, dout2;
    logic [3:0]  select, select_bar, u_out, c_out;
    logic [3:0]  select2, select_bar2, u_out2, c_out2;

    int tests = 0;
    int fails = 0;

    logic [3:0] sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic inj_rail = 1'b0;
    logic inj_pre  = 1'b0;
    int   rises    = 0;
    int   viol     = 0;
    int   low_run  = 0;
    logic       pre_q = 1'b0;
    logic [3:0] sel_q = 4'h0;

    always #5 clk = ~clk;

    bdd_sbox_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .busy(busy), .done(done), .dout(dout), .fault(fault),
        .pre(pre), .select(select), .select_bar(select_bar),
        .u_out(u_out), .c_out(c_out)
    );

    bdd_sbox_sequencer #(.NIBBLES(16), .PRE_CYCLES(2), .EVAL_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .din(din2),
        .busy(busy2), .done(done2), .dout(dout2), .fault(fault2),
        .pre(pre2), .select(select2), .select_bar(select_bar2),
        .u_out(u_out2), .c_out(c_out2)
    );

    // Dual-rail S-box array: rails read 0 while precharged, true/complement when evaluating
    always_comb begin
        u_out = 4'h0;
        c_out = 4'h0;
        if (pre) begin
            u_out = sbox_t[select];
            c_out = ~sbox_t[select];
            if (inj_rail && rises == 6) c_out[2] = u_out[2];
        end else if (inj_pre) begin
            u_out[0] = 1'b1;
        end
    end

    always_comb begin
        u_out2 = 4'h0;
        c_out2 = 4'h0;
        if (pre2) begin
            u_out2 = sbox_t[select2];
            c_out2 = ~sbox_t[select2];
        end
    end

    // Phase monitor: counts pre rising edges and rule violations per operation
    always @(negedge clk) begin
        if (start && !busy && !done) begin
            rises   = 0;
            viol    = 0;
            low_run = 0;
        end else begin
            if (select_bar !== ~select) viol++;
            if (pre && select !== sel_q) viol++;
            if (pre && !pre_q) begin
                rises++;
                if (low_run < 1) viol++;
            end
            if (!pre) low_run = (!pre_q && select === sel_q) ? low_run + 1 : 1;
        end
        pre_q = pre;
        sel_q = select;
    end

    function automatic logic [63:0] subst(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox_t[d[4*i +: 4]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, fault, pre, select, select_bar}), 64'h00F);
        check({tag, "_dout"}, dout, 64'h0);
    endtask

    // One operation on dut: start in cycle 0, optional ignored starts and a reset pulse
    task automatic run(input logic [63:0] d, input int ign1, input int ign2,
                       input int rst_at, output int done_cyc);
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        din   = d;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(negedge clk);
            if (done && done_cyc == 0) done_cyc = cyc;
            if (rst_at > 0 && cyc == rst_at + 1) check_reset_vals("mid_reset");
            start = (cyc == ign1 || cyc == ign2);
            din   = start ? ~d : d;
            rst_n = !(cyc == rst_at);
            if (done_cyc != 0 && cyc > done_cyc) break;
        end
        start = 1'b0;
        din   = d;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] d0, d;
        int dc;
        d0     = 64'h0123456789ABCDEF;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        din    = 64'h0;
        din2   = 64'h0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        run(d0, 0, 0, 0, dc);
        check("func_done_cyc", 64'(dc), 64'd49);
        check("func_dout", dout, subst(d0));
        check("func_fault", 64'(fault), 64'd0);
        check("phase_rises", 64'(rises), 64'd16);
        check("phase_viol", 64'(viol), 64'd0);

        inj_rail = 1'b1;
        run(d0, 0, 0, 0, dc);
        inj_rail = 1'b0;
        check("rail_fault", 64'(fault), 64'd1);
        check("rail_dout", dout, subst(d0));

        run(d0, 0, 0, 0, dc);
        check("clean_fault", 64'(fault), 64'd0);
        check("clean_done_cyc", 64'(dc), 64'd49);

        inj_pre = 1'b1;
        run(d0, 0, 0, 0, dc);
        inj_pre = 1'b0;
        check("prefault_fault", 64'(fault), 64'd1);
        check("prefault_dout", dout, subst(d0));

        run(d0, 0, 0, 20, dc);
        check("reset_no_done", 64'(dc), 64'd0);

        d = {$urandom, $urandom};
        run(d, 0, 0, 0, dc);
        check("after_reset_done_cyc", 64'(dc), 64'd49);
        check("after_reset_dout", dout, subst(d));
        check("after_reset_fault", 64'(fault), 64'd0);

        d = {$urandom, $urandom};
        run(d, 10, 49, 0, dc);
        check("ignstart_done_cyc", 64'(dc), 64'd49);
        check("ignstart_dout", dout, subst(d));
        @(negedge clk);
        check("ignstart_idle", 64'({busy, done}), 64'd0);

        for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom};
            run(d, 0, 0, 0, dc);
            check("rand_done_cyc", 64'(dc), 64'd49);
            check("rand_dout", dout, subst(d));
            check("rand_phase", 64'({rises[7:0], viol[7:0]}), 64'h1000);
        end

        d = {$urandom, $urandom};
        @(negedge clk);
        start2 = 1'b1;
        din2   = d;
        @(negedge clk);
        start2 = 1'b0;
        dc = 0;
        for (int cyc = 1; cyc <= 200 && dc == 0; cyc++) begin
            if (done2) dc = cyc;
            else @(negedge clk);
        end
        check("p2e3_done_cyc", 64'(dc), 64'd81);
        check("p2e3_dout", dout2, subst(d));
        check("p2e3_fault", 64'(fault2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
